// File: rtl/alloc_pkg.sv
// alloc_pkg: helpers shared by the allocators (array sizing, owner index
// type, one-hot priority rotation).
package alloc_pkg;

    // Widest priority vector the rotate helpers handle
    localparam int MAX_N = 32;

    typedef logic [MAX_N-1:0] onehot_t;

    // Owner index wide enough for any supported requester count
    typedef logic [$clog2(MAX_N)-1:0] owner_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Bits needed to hold an index into n entries (at least one)
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Rotate the low n bits of v left by one position
    function automatic onehot_t rotl_onehot(input onehot_t v, input int n);
        onehot_t mask;
        mask = (n >= MAX_N) ? '1 : ((onehot_t'(1) << n) - onehot_t'(1));
        return ((v << 1) | (v >> (n - 1))) & mask;
    endfunction

    // Rotate the low n bits of v right by one position
    function automatic onehot_t rotr_onehot(input onehot_t v, input int n);
        onehot_t mask;
        mask = (n >= MAX_N) ? '1 : ((onehot_t'(1) << n) - onehot_t'(1));
        return ((v >> 1) | (v << (n - 1))) & mask;
    endfunction

endpackage

// File: rtl/allocator_wavefront_locked_if.sv
// allocator_wavefront_locked_if: request/grant bundle of the locked wavefront
// allocator. requests_i[i][j]: requester i wants resource j;
// grants_o[j][i]: resource j granted to requester i.
interface allocator_wavefront_locked_if #(
    parameter int NUM_REQS = 4,
    parameter int NUM_RESS = 4
);
    logic [NUM_REQS-1:0][NUM_RESS-1:0] requests_i;
    logic [NUM_REQS-1:0]               release_i;
    logic [NUM_RESS-1:0]               res_avail_i;
    logic [NUM_RESS-1:0][NUM_REQS-1:0] grants_o;
    logic [NUM_RESS-1:0]               locked_o;

    modport master (output requests_i, release_i, res_avail_i,
                    input  grants_o, locked_o);
    modport slave  (input  requests_i, release_i, res_avail_i,
                    output grants_o, locked_o);
endinterface

// File: rtl/wavefront_core.sv
// wavefront_core: combinational N x N wavefront array, diagonal 0 has the
// highest priority, then diagonals 1..N-1. Cell (r,c) lies on (r+c)%N.
module wavefront_core #(
    parameter int N = 4
) (
    input  logic [N-1:0][N-1:0] req_i,
    output logic [N-1:0][N-1:0] gnt_o
);

    // Sweep diagonals in priority order; cells of one diagonal never share
    // a row or column, so they can be resolved in any order.
    always_comb begin
        logic [N-1:0] row_free;
        logic [N-1:0] col_free;
        int           c;
        gnt_o    = '0;
        row_free = '1;
        col_free = '1;
        c        = 0;
        for (int d = 0; d < N; d++) begin
            for (int r = 0; r < N; r++) begin
                c = (d - r + N) % N;
                if (req_i[r][c] && row_free[r] && col_free[c]) begin
                    gnt_o[r][c] = 1'b1;
                    row_free[r] = 1'b0;
                    col_free[c] = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/allocator_wavefront_locked.sv
// allocator_wavefront_locked: round-robin wavefront allocator with registered
// grants and packet-level grant locking.
// Optional feature macro: ALLOC_WF_LOCK_EN (lock table, release, locked output).
module allocator_wavefront_locked
    import alloc_pkg::*;
#(
    parameter int NUM_REQS = 4,
    parameter int NUM_RESS = 4
) (
    input  logic clk,
    input  logic reset_n,
    allocator_wavefront_locked_if.slave bus
);

    localparam int N  = max_int(NUM_REQS, NUM_RESS);
    localparam int OW = idx_width(NUM_REQS);

    logic [N-1:0][N-1:0]               pad_req;
    logic [N-1:0][N-1:0]               rot_req;
    logic [N-1:0][N-1:0]               rot_gnt;
    logic [N-1:0][N-1:0]               fresh_gnt;
    logic [NUM_RESS-1:0][NUM_REQS-1:0] lock_gnt;
    logic [NUM_RESS-1:0][NUM_REQS-1:0] grants_d;
    logic [NUM_RESS-1:0][NUM_REQS-1:0] grants_q;
    logic [NUM_REQS-1:0]               busy;
    logic [NUM_RESS-1:0]               lock_v;
    logic [N-1:0]                      prio_q;
    logic [N-1:0]                      prio_d;
    logic                              any_fresh;

`ifdef ALLOC_WF_LOCK_EN
    logic [NUM_RESS-1:0]         lock_v_q;
    logic [NUM_RESS-1:0]         lock_v_d;
    logic [NUM_RESS-1:0][OW-1:0] owner_q;
    logic [NUM_RESS-1:0][OW-1:0] owner_d;

    // Derive busy requesters and the grants carried by existing locks
    always_comb begin
        busy     = '0;
        lock_gnt = '0;
        for (int j = 0; j < NUM_RESS; j++) begin
            for (int i = 0; i < NUM_REQS; i++) begin
                if (lock_v_q[j] && owner_q[j] == OW'(i)) begin
                    busy[i]        = 1'b1;
                    lock_gnt[j][i] = bus.res_avail_i[j] & bus.requests_i[i][j];
                end
            end
        end
    end

    // Release frees the owner's lock; a fresh grant locks unless it is a single-flit packet
    always_comb begin
        lock_v_d = lock_v_q;
        owner_d  = owner_q;
        for (int j = 0; j < NUM_RESS; j++) begin
            for (int i = 0; i < NUM_REQS; i++) begin
                if (lock_v_q[j] && owner_q[j] == OW'(i) && bus.release_i[i])
                    lock_v_d[j] = 1'b0;
                if (fresh_gnt[i][j] && !bus.release_i[i]) begin
                    lock_v_d[j] = 1'b1;
                    owner_d[j]  = OW'(i);
                end
            end
        end
    end

    // Lock table registers; reset drops every lock at once
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lock_v_q <= '0;
            owner_q  <= '0;
        end else begin
            lock_v_q <= lock_v_d;
            owner_q  <= owner_d;
        end
    end

    assign lock_v = lock_v_q;
`else
    logic unused_release;
    assign unused_release = ^bus.release_i;
    assign busy           = '0;
    assign lock_gnt       = '0;
    assign lock_v         = '0;
`endif

    // Fresh request matrix: missing rows/columns stay zero
    always_comb begin
        pad_req = '0;
        for (int i = 0; i < NUM_REQS; i++)
            for (int j = 0; j < NUM_RESS; j++)
                pad_req[i][j] = bus.requests_i[i][j] & ~busy[i] & ~lock_v[j]
                              & bus.res_avail_i[j];
    end

    // Shift rows so the priority diagonal lands on diagonal 0 of the array
    always_comb begin
        rot_req = '0;
        for (int k = 0; k < N; k++)
            if (prio_q[k])
                for (int r = 0; r < N; r++)
                    rot_req[r] = rot_req[r] | pad_req[(r + k) % N];
    end

    wavefront_core #(.N(N)) u_core (
        .req_i (rot_req),
        .gnt_o (rot_gnt)
    );

    // Shift the array result back to requester order
    always_comb begin
        fresh_gnt = '0;
        for (int k = 0; k < N; k++)
            if (prio_q[k])
                for (int r = 0; r < N; r++)
                    fresh_gnt[(r + k) % N] = fresh_gnt[(r + k) % N] | rot_gnt[r];
    end

    // Merge fresh and locked grants; advance priority only when something fresh was granted
    always_comb begin
        grants_d = '0;
        for (int j = 0; j < NUM_RESS; j++)
            for (int i = 0; i < NUM_REQS; i++)
                grants_d[j][i] = fresh_gnt[i][j] | lock_gnt[j][i];
        any_fresh = |fresh_gnt;
        prio_d    = any_fresh ? N'(rotl_onehot(onehot_t'(prio_q), N)) : prio_q;
    end

    // Output and priority registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            grants_q <= '0;
            prio_q   <= {{(N-1){1'b0}}, 1'b1};
        end else begin
            grants_q <= grants_d;
            prio_q   <= prio_d;
        end
    end

    assign bus.grants_o = grants_q;
    assign bus.locked_o = lock_v;

endmodule
